// File: rtl/rx_intf_dma_sched_if.sv
// Descriptor intake and stream-launch signals between RX logic, the scheduler and the DMA stream slave.
interface rx_intf_dma_sched_if #(
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
);
  logic                              pkt_valid;
  logic                              pkt_ready;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_num_symbol;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] dma_num_symbol;
  logic                              dma_start;
  logic                              beat_fire;
  logic                              tlast_out;

  // master: the scheduler; slave: descriptor source plus stream beat monitor
  modport master (
    input  pkt_valid, pkt_num_symbol, beat_fire,
    output pkt_ready, dma_num_symbol, dma_start, tlast_out
  );
  modport slave (
    output pkt_valid, pkt_num_symbol, beat_fire,
    input  pkt_ready, dma_num_symbol, dma_start, tlast_out
  );
endinterface

// File: rtl/rx_intf_dma_sched.sv
// Queues RX packet descriptors and launches one AXI-Stream DMA transfer per descriptor,
// tracking beats, flagging the last beat and raising done/timeout events.
module rx_intf_dma_sched #(
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int DESC_DEPTH_LOG2        = 2,
  parameter int TIMEOUT_WIDTH          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [TIMEOUT_WIDTH-1:0]   timeout_cfg,
  rx_intf_dma_sched_if.master        dma,
  output logic                       busy,
  output logic [DESC_DEPTH_LOG2:0]   queue_count,
  output logic                       irq_done,
  output logic                       irq_timeout,
  output logic [7:0]                 zero_len_cnt
);
  localparam int SW    = MAX_BIT_NUM_DMA_SYMBOL;
  localparam int DEPTH = 1 << DESC_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]              q_mem [DEPTH];
  logic [DESC_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0]              num_r, beat_cnt;
  logic [TIMEOUT_WIDTH-1:0]   to_cnt;
  logic                       hs, push, pop, zero_hs, last_beat, to_hit, in_xfer;

  assign dma.pkt_ready = !rst && (queue_count < (DESC_DEPTH_LOG2+1)'(DEPTH));
  assign hs        = dma.pkt_valid && dma.pkt_ready;
  assign push      = hs && (dma.pkt_num_symbol != '0);
  assign zero_hs   = hs && (dma.pkt_num_symbol == '0);
  assign pop       = (state == START);
  assign in_xfer   = (state == XFER);
  assign last_beat = dma.beat_fire && (beat_cnt == num_r);
  // to_cnt reaches timeout_cfg on this edge; a beat in the same cycle wins
  assign to_hit    = !dma.beat_fire && (timeout_cfg != '0) && (to_cnt == timeout_cfg - 1'b1);

  assign dma.dma_start      = (state == START);
  assign dma.dma_num_symbol = num_r;
  assign dma.tlast_out      = in_xfer && (beat_cnt == num_r);
  assign busy               = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && queue_count != '0) state_nxt = START;
      START:   state_nxt = XFER;
      XFER:    if (last_beat || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // descriptor storage needs no reset: only entries counted by queue_count are read
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= dma.pkt_num_symbol;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      queue_count  <= '0;
      num_r        <= '0;
      beat_cnt     <= '0;
      to_cnt       <= '0;
      irq_done     <= 1'b0;
      irq_timeout  <= 1'b0;
      zero_len_cnt <= '0;
    end else begin
      state       <= state_nxt;
      irq_done    <= in_xfer && last_beat;
      irq_timeout <= in_xfer && to_hit;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      queue_count <= queue_count + 1'b1;
      else if (pop && !push) queue_count <= queue_count - 1'b1;

      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        num_r    <= q_mem[rd_ptr] - 1'b1;
        beat_cnt <= '0;
        to_cnt   <= '0;
      end else if (in_xfer) begin
        if (dma.beat_fire) begin
          if (!last_beat) beat_cnt <= beat_cnt + 1'b1;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      if (zero_hs && zero_len_cnt != 8'hFF) zero_len_cnt <= zero_len_cnt + 1'b1;
    end
  end
endmodule

// File: doc/rx_intf_dma_sched.md
# rx_intf_dma_sched

Descriptor-driven sequencer for the RX AXI-Stream path into the host DMA. Upstream RX logic posts one descriptor per packet, giving the packet length in 64-bit symbols. The block queues up to 2^DESC_DEPTH_LOG2 descriptors and launches one stream transfer per descriptor, presenting the symbol limit the stream slave expects. It counts accepted beats, flags the last beat, and raises done or timeout events for the interrupt logic.

## Interface
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of symbol counts and limits
- DESC_DEPTH_LOG2, 2, log2 of descriptor queue depth (default depth 4)
- TIMEOUT_WIDTH, 16, width of the stall-timeout counter
- clk  in  1  single clock for all logic
- rst  in  1  reset; synchronous, active-high
- enable  in  1  1 = new transfers may start; 0 = current transfer completes, no new start
- pkt_valid  in  1  descriptor offered
- pkt_num_symbol  in  MAX_BIT_NUM_DMA_SYMBOL  packet length N in beats
- pkt_ready  out  1  queue accepts descriptor; = !rst && queue_count < depth (combinational)
- dma_num_symbol  out  MAX_BIT_NUM_DMA_SYMBOL  N-1 of the active transfer; slave inclusive-limit convention
- dma_start  out  1  one-cycle pulse at transfer launch
- beat_fire  in  1  tvalid && tready of the stream beat
- tlast_out  out  1  current beat is the final beat of the transfer
- timeout_cfg  in  TIMEOUT_WIDTH  idle cycles tolerated between beats in XFER; 0 disables
- busy  out  1  state != IDLE
- queue_count  out  DESC_DEPTH_LOG2+1  descriptors queued, excluding the active one
- irq_done  out  1  one-cycle pulse, transfer completed
- irq_timeout  out  1  one-cycle pulse, transfer aborted by timeout
- zero_len_cnt  out  8  saturating count of rejected zero-length descriptors

## Operation
- Push: pkt_valid && pkt_ready && pkt_num_symbol != 0 writes the circular queue.
- Zero-length descriptor: handshake completes with no write, and zero_len_cnt increments, saturating at 255.
- Full: pkt_ready = 0. A pop in the same cycle does not re-open acceptance that cycle.
- Simultaneous push and pop: queue_count unchanged, and both take effect.
- FSM states: IDLE, START, XFER.
  - IDLE -> START when enable && queue_count != 0.
  - START: pop head, load dma_num_symbol = N-1, clear beat_cnt and the timeout counter, assert dma_start. Always goes to XFER next cycle.
  - XFER, beat_fire with beat_cnt == dma_num_symbol: irq_done next cycle, -> IDLE.
  - XFER, other beat_fire: beat_cnt + 1, timeout counter cleared.
  - XFER, no beat_fire: timeout counter + 1. At count == timeout_cfg (timeout_cfg != 0), irq_timeout next cycle, -> IDLE. The descriptor is discarded.
  - A beat_fire in the timeout cycle takes priority: it counts as a beat, and no timeout occurs.
- tlast_out = (state == XFER) && beat_cnt == dma_num_symbol (combinational).
- beat_fire outside XFER is ignored.
- dma_num_symbol holds its value until the next START.
- enable deassert mid-XFER does not abort.
- All counters are unsigned. beat_cnt is MAX_BIT_NUM_DMA_SYMBOL bits and never wraps, since it stops at dma_num_symbol.

## Timing
- Reset: state IDLE, queue emptied, pointers 0, zero_len_cnt 0.
  - dma_num_symbol, dma_start, tlast_out, busy, queue_count, irq_done, irq_timeout all 0.
  - pkt_ready 0 while rst = 1.
- Reset mid-transfer: abort immediately. No irq pulse, and queued descriptors are lost.
- Push at edge t: queue_count increments at t+1, START at t+2 (dma_start high), XFER from t+3.
- Final beat_fire at cycle c: irq_done and IDLE at c+1. The earliest next dma_start is c+2.
- Minimum per-transfer overhead: 2 cycles (IDLE, START).
- Timeout: with the last beat (or START) at cycle s, irq_timeout is asserted at s + timeout_cfg + 1.

## Test plan
- Single packet: push N=4, beat_fire every cycle from first XFER.
  - dma_start once, dma_num_symbol = 3.
  - tlast_out on the 4th beat only, irq_done 1 cycle later, queue_count back to 0.
- Queue full: push 6 descriptors (N=1..6) back-to-back while beat_fire = 0 and enable = 0.
  - Exactly 4 accepted, pkt_ready = 0 after the 4th, queue_count = 4.
  - After enable = 1, launches run in order with dma_num_symbol 0,1,2,3.
- Zero length: push N=0, then N=2.
  - zero_len_cnt = 1, only one dma_start, dma_num_symbol = 1.
- Timeout: timeout_cfg = 5, N=8, stop beat_fire after 3 beats.
  - irq_timeout 6 cycles after the 3rd beat, no irq_done, next queued descriptor starts.
  - Repeat with a beat at idle count 5: no timeout.
- Enable/reset mid-operation: deassert enable during XFER of N=3, with 2 queued.
  - Transfer finishes with irq_done, no further dma_start until enable = 1.
  - Assert rst during XFER: all outputs 0 next cycle, queue_count 0, no irq pulses.
